// File: rtl/small_decimator.sv
// small_decimator: keeps one input sample in every M and queues kept samples in a valid/ready output FIFO.
module small_decimator #(
    parameter int WIDTH      = 8,
    parameter int RATIO_BITS = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic                  i_in_valid,
    input  logic [WIDTH-1:0]      i_data_in,
    input  logic [RATIO_BITS-1:0] i_ratio_m1,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [WIDTH-1:0]      o_data_out,
    output logic                  o_overflow,
    input  logic                  i_clr_ovf
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

    logic [RATIO_BITS-1:0] r_phase, r_ratio;
    logic [AW-1:0]         r_rd, r_wr;
    logic [AW:0]           r_count;
    logic [WIDTH-1:0]      r_mem [FIFO_DEPTH];
    logic                  r_ovf;
    logic                  w_keep, w_pop, w_push;

    assign w_keep      = i_in_valid && (r_phase == '0);
    assign w_pop       = (r_count != '0) && i_out_ready;
    // a full FIFO still accepts when the head leaves in the same cycle
    assign w_push      = w_keep && ((r_count != FULL) || w_pop);
    assign o_out_valid = (r_count != '0);
    assign o_data_out  = r_mem[r_rd];
    assign o_overflow  = r_ovf;

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_phase <= '0;
            r_ratio <= '0;
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (i_in_valid) begin
                if (r_phase == '0) begin
                    r_ratio <= i_ratio_m1;
                    r_phase <= (i_ratio_m1 == '0) ? '0 : RATIO_BITS'(1);
                end else begin
                    r_phase <= (r_phase == r_ratio) ? '0 : r_phase + RATIO_BITS'(1);
                end
            end
            if (w_push) begin
                r_mem[r_wr] <= i_data_in;
                r_wr        <= r_wr + AW'(1);
            end
            if (w_pop) r_rd <= r_rd + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            if (w_keep && !w_push) r_ovf <= 1'b1;
            else if (i_clr_ovf)    r_ovf <= 1'b0;
        end
    end
endmodule

// File: doc/small_decimator.md
# small_decimator

Integer-ratio decimator with buffered output, placed directly downstream of the single-pole low-pass filter. It consumes the filter's output samples on the filter enable strobe and keeps one sample in every M. Kept samples go into a small FIFO and leave on a valid/ready handshake, so a slower consumer (serializer, DMA, CPU read port) can back-pressure without stalling the filter. The filter already band-limits the signal, so no further anti-alias arithmetic happens here.

## Interface
- WIDTH, 8: sample width in bits, signed two's complement; matches the filter's WIDTH.
- RATIO_BITS, 4: width of the ratio input; M ranges from 1 to 2^RATIO_BITS.
- FIFO_DEPTH, 4: output FIFO entries; must be a power of two, ≥ 2.
- clk  in  1  system clock; all logic is on the rising edge.
- rstN  in  1  reset, synchronous and active-low.
- inValid  in  1  input sample strobe; driven by the same signal as the filter's en.
- dataIn  in  WIDTH  signed input sample (the filter's dataOut), sampled when inValid=1.
- ratioM1  in  RATIO_BITS  decimation factor minus one (M = ratioM1+1).
- outValid  out  1  FIFO non-empty; dataOut holds a valid sample.
- outReady  in  1  consumer accepts dataOut when outValid && outReady.
- dataOut  out  WIDTH  signed head-of-FIFO sample.
- overflow  out  1  sticky flag: at least one kept sample was dropped because the FIFO was full.
- clrOvf  in  1  clears overflow (single-cycle pulse).

## Operation
- Phase counter `phase` (RATIO_BITS wide) counts accepted input samples. It advances only on inValid=1.
- On inValid=1 with phase==0: the sample is "kept" (push request), and ratioM1 is latched into ratioReg.
  - If ratioReg(new)==0, phase stays 0; otherwise phase←1.
- On inValid=1 with phase!=0: the sample is discarded.
  - If phase==ratioReg, phase←0; otherwise phase←phase+1.
- A ratioM1 change takes effect only at the next kept sample; a group already in progress finishes with the old ratio.
- M=1 (ratioM1=0): every input sample is kept.
- FIFO: circular buffer with rdPtr/wrPtr of log2(FIFO_DEPTH) bits, plus a count of log2(FIFO_DEPTH)+1 bits. Pointers wrap modulo FIFO_DEPTH.
- Pop occurs when outValid && outReady.
- A push succeeds if count<FIFO_DEPTH, or if count==FIFO_DEPTH and a pop happens in the same cycle.
- Failed push: the sample is dropped, pointers and count are unchanged, and overflow←1.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pop with count==0 cannot happen, because outValid=0.
- dataOut = mem[rdPtr]. outValid = (count!=0). No arithmetic is done on samples; values pass bit-exact.
- overflow: set by a failed push, cleared by clrOvf. If both occur in the same cycle, set wins (overflow=1).
- Reset (rstN=0 at a clock edge), including mid-group or mid-handshake:
  - phase=0, ratioReg=0, pointers=0, count=0.
  - All mem entries are cleared to 0.
  - Outputs after reset: outValid=0, dataOut=0, overflow=0.
  - inValid and outReady are ignored while rstN=0.

## Timing
- Latency: a kept sample at edge t appears on dataOut with outValid=1 after edge t, provided the FIFO was empty (one cycle).
- With the FIFO non-empty, the kept sample is visible after all earlier entries have been popped.
- Throughput: one push and one pop per cycle. Sustained rate is set by inValid/M.
- outValid never depends combinationally on outReady.
- dataOut and outValid are stable while outValid=1 && outReady=0.
- After a successful push into an empty FIFO, outValid rises at the next cycle, never in the same cycle.
- Reset takes effect at the first rising edge with rstN=0; normal operation resumes at the first edge with rstN=1.

## Test plan
- Basic decimation:
  - Stimulus: reset, ratioM1=3, outReady=1, inValid=1 every cycle, dataIn=0,1,2,…,15.
  - Required: outputs 0,4,8,12, one cycle after each kept sample; overflow stays 0.
- Ratio change mid-group:
  - Stimulus: ratioM1=2, inputs 0..4 on strobes; set ratioM1=0 after input 4; inputs 5..7 follow.
  - Required: kept samples 0,3,6,7. Input 6 starts the first new group; input 5 finishes the old group.
- Sparse strobe:
  - Stimulus: ratioM1=1, inValid high every 3rd cycle, dataIn=-5,-4,-3,-2.
  - Required: outputs -5 and -3; the phase counter does not advance on idle cycles.
- Back-pressure and overflow:
  - Stimulus: FIFO_DEPTH=4, ratioM1=0, outReady=0, push 10,11,12,13,14; then pulse clrOvf together with a failed push of 15; then raise outReady.
  - Required: overflow=1 after 14 and still 1 after the clrOvf cycle; outputs 10,11,12,13 in order; a later clrOvf without a failed push clears the flag.
- Full with simultaneous pop:
  - Stimulus: FIFO full (20..23), outReady=1, and push 24 in the same cycle.
  - Required: 20 is popped, 24 is accepted, overflow stays 0, and the subsequent outputs are 21,22,23,24.
- Reset mid-operation:
  - Stimulus: assert rstN=0 for one cycle with 2 entries queued and phase=2.
  - Required: outValid=0, dataOut=0, overflow=0 after the edge. The next strobe is kept (phase restarted at 0).
